// File: rtl/ram_arbiter.sv
// Two-port CPU/DMA arbiter in front of a single-port RAM. CPU has priority and DMA is protected by a starvation counter.
// Optional RAM_ARB_RDATA_HOLD_EN keeps the last read word on each port's dout between reads.
module ram_arbiter #(
    parameter int ADDR_MSB   = 6,
    parameter int STARVE_MAX = 3
) (
    input  logic              mclk,
    input  logic              puc_rst,
    input  logic              cpu_req,
    input  logic [ADDR_MSB:0] cpu_addr,
    input  logic [1:0]        cpu_wen,
    input  logic [15:0]       cpu_din,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [15:0]       cpu_dout,
    input  logic              dma_req,
    input  logic [ADDR_MSB:0] dma_addr,
    input  logic [1:0]        dma_wen,
    input  logic [15:0]       dma_din,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [15:0]       dma_dout,
    output logic [ADDR_MSB:0] ram_addr,
    output logic              ram_cen,
    output logic [1:0]        ram_wen,
    output logic [15:0]       ram_din,
    input  logic [15:0]       ram_dout
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0] starve_cnt;
    logic       starved;
    logic       rd_cpu;
    logic       rd_dma;

    assign starved = (starve_cnt == STARVE_LIM);

    always_comb begin
        cpu_gnt = 1'b0;
        dma_gnt = 1'b0;
        if (!puc_rst) begin
            if (cpu_req && !(dma_req && starved)) begin
                cpu_gnt = 1'b1;
            end else if (dma_req) begin
                dma_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        ram_addr = '0;
        ram_wen  = 2'b11;
        ram_din  = 16'h0000;
        if (cpu_gnt) begin
            ram_addr = cpu_addr;
            ram_wen  = cpu_wen;
            ram_din  = cpu_din;
        end else if (dma_gnt) begin
            ram_addr = dma_addr;
            ram_wen  = dma_wen;
            ram_din  = dma_din;
        end
    end

    assign ram_cen = ~(cpu_gnt | dma_gnt);

    always_ff @(posedge mclk) begin
        if (puc_rst) begin
            starve_cnt <= 4'd0;
        end else if (dma_req && !dma_gnt) begin
            if (!starved) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end else begin
            starve_cnt <= 4'd0;
        end
    end

    always_ff @(posedge mclk) begin
        if (puc_rst) begin
            rd_cpu <= 1'b0;
            rd_dma <= 1'b0;
        end else begin
            rd_cpu <= cpu_gnt && (cpu_wen == 2'b11);
            rd_dma <= dma_gnt && (dma_wen == 2'b11);
        end
    end

    // A read granted just before reset must not surface while reset is high.
    assign cpu_rvalid = rd_cpu & ~puc_rst;
    assign dma_rvalid = rd_dma & ~puc_rst;

`ifdef RAM_ARB_RDATA_HOLD_EN
    logic [15:0] hold_cpu;
    logic [15:0] hold_dma;

    always_ff @(posedge mclk) begin
        if (puc_rst) begin
            hold_cpu <= 16'h0000;
            hold_dma <= 16'h0000;
        end else begin
            if (cpu_rvalid) begin
                hold_cpu <= ram_dout;
            end
            if (dma_rvalid) begin
                hold_dma <= ram_dout;
            end
        end
    end

    assign cpu_dout = puc_rst ? 16'h0000 : (cpu_rvalid ? ram_dout : hold_cpu);
    assign dma_dout = puc_rst ? 16'h0000 : (dma_rvalid ? ram_dout : hold_dma);
`else
    assign cpu_dout = cpu_rvalid ? ram_dout : 16'h0000;
    assign dma_dout = dma_rvalid ? ram_dout : 16'h0000;
`endif

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter that shares the single-port scalable RAM between the CPU data path and a DMA requester. It grants at most one access per cycle, drives the RAM's low-active chip enable and byte write enables, and routes the one-cycle-latency read data back to the requester that issued the read. CPU has priority; a starvation counter guarantees DMA forward progress. Sits between the two masters and the RAM instance in the bench and core memory subsystem.

## Interface

- ADDR_MSB, 6, MSB of the RAM word address; must match the RAM instance.
- STARVE_MAX, 3, consecutive denied DMA cycles before DMA is forced ahead of CPU; legal range 1..15.

- mclk  in  1  clock; RAM clock is the same net.
- puc_rst  in  1  reset, synchronous, active-high.
- cpu_req  in  1  CPU access request.
- cpu_addr  in  ADDR_MSB+1  CPU word address.
- cpu_wen  in  2  CPU byte write enables, low active; 2'b11 = read.
- cpu_din  in  16  CPU write data.
- cpu_gnt  out  1  CPU access accepted this cycle.
- cpu_rvalid  out  1  CPU read data valid on cpu_dout.
- cpu_dout  out  16  CPU read data.
- dma_req, dma_addr, dma_wen, dma_din, dma_gnt, dma_rvalid, dma_dout: same as cpu_* for the DMA port.
- ram_addr  out  ADDR_MSB+1  RAM address.
- ram_cen  out  1  RAM chip enable, low active.
- ram_wen  out  2  RAM byte write enables, low active.
- ram_din  out  16  RAM write data.
- ram_dout  in  16  RAM read data, valid the cycle after the access.

## Operation

- Grant is combinational from req and starve_cnt, forced 0 while puc_rst is high.
  - Only one port requesting: that port is granted.
  - Both ports requesting: CPU is granted unless starve_cnt == STARVE_MAX, in which case DMA is granted.
- starve_cnt is 4 bits, reset 0:
  - Increments when dma_req && !dma_gnt, saturating at STARVE_MAX.
  - Clears on dma_gnt or !dma_req.
- RAM drive:
  - ram_cen = ~(cpu_gnt | dma_gnt).
  - ram_addr, ram_wen and ram_din are taken from the granted port.
  - No grant: ram_addr = 0, ram_wen = 2'b11, ram_din = 0.
- Requester rule:
  - Hold req, addr, wen and din stable until gnt is high at a rising edge. That edge completes the access.
  - Back-to-back accesses are allowed; req may stay high.
- Read tracking:
  - A granted access with wen == 2'b11 sets rd_cpu or rd_dma at the next edge, giving a 1-cycle rvalid pulse.
  - Writes, including partial 2'b01 and 2'b10, never produce rvalid.
  - rd_* resets to 0.
- dout routing: x_dout = x_rvalid ? ram_dout : 16'h0000. The alternative behaviour is described under Configuration.
- A read and a write to the same address in consecutive cycles by different ports are serviced in grant order, with no forwarding.

## Timing

- Grant latency: 0 cycles, same cycle as req when not blocked.
- Read latency: rvalid and dout arrive 1 cycle after the gnt cycle.
- Throughput: 1 access per cycle total.
- Maximum DMA wait under continuous CPU traffic: STARVE_MAX cycles, with the grant in cycle STARVE_MAX+1.
- Reset values:
  - cpu_gnt, dma_gnt, cpu_rvalid and dma_rvalid are 0.
  - cpu_dout and dma_dout are 16'h0000.
  - ram_cen is 1, ram_wen is 2'b11, and ram_addr and ram_din are 0.
- Reset mid-operation:
  - A read granted in the cycle before puc_rst is asserted is dropped: no rvalid is produced.
  - starve_cnt clears.
  - The first grant is possible in the cycle after puc_rst deasserts.

## Configuration

- RAM_ARB_RDATA_HOLD_EN:
  - Defined: each port has a 16-bit hold register, reset 0, loaded with ram_dout when x_rvalid is high. x_dout = x_rvalid ? ram_dout : hold_x, so the last read value persists until that port's next read, across other-port traffic.
  - Undefined: no hold registers; x_dout is 16'h0000 outside rvalid cycles.

## Test plan

- CPU-only read after writing 16'hA55A to addr 5 -> cpu_gnt is high in the req cycle; cpu_rvalid is high with cpu_dout = 16'hA55A in the next cycle; dma_rvalid stays 0.
- Byte write: CPU writes 16'h1234 to addr 2, then DMA writes 16'hABCD with wen 2'b01, then DMA reads -> dma_dout = 16'hAB34.
- Continuous simultaneous req, STARVE_MAX = 3 -> CPU is granted for 3 cycles, DMA in cycle 4, and the pattern repeats. starve_cnt never exceeds 3.
- Reads alternating CPU, DMA, CPU to addrs 1, 2, 3 holding 16'h0001, 16'h0002, 16'h0003 -> each rvalid appears only on the issuing port with the correct data, 1 cycle after its grant.
- puc_rst asserted in the cycle after a granted CPU read -> cpu_rvalid stays 0, ram_cen is 1, both grants are 0, and dout is 0 (the hold register is also 0 when the macro is defined).
- With RAM_ARB_RDATA_HOLD_EN defined: CPU reads 16'hBEEF, then DMA does 4 accesses -> cpu_dout stays 16'hBEEF throughout. Without the macro, cpu_dout returns to 0 after the rvalid cycle.
